// File: rtl/mul_seq_ctrl_pkg.sv
// Shared CPU-side definitions for the sequential multiplier controller.
package mul_seq_ctrl_pkg;

  localparam int XLEN = 32;

  // EX-stage ALU type code that selects the MUL unit.
  localparam logic [3:0] ALU_TYPE_MUL = 4'b0101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_seq_ctrl_radix_step.sv
// One radix-2^RADIX_BITS shift-add iteration, purely combinational.
// Consumes the low RADIX_BITS of the multiplier and advances both operands.
module mul_radix_step #(
  parameter int XLEN       = 32,
  parameter int RADIX_BITS = 4
) (
  input  logic [XLEN-1:0] acc_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] acc_o,
  output logic [XLEN-1:0] a_o,
  output logic [XLEN-1:0] b_o
);

  logic [XLEN-1:0] digit_s;

  // Partial product of the multiplicand and the current digit, accumulated mod 2^XLEN.
  always_comb begin
    digit_s = {{(XLEN-RADIX_BITS){1'b0}}, b_i[RADIX_BITS-1:0]};
    acc_o   = acc_i + (a_i * digit_s);
    a_o     = a_i << RADIX_BITS;
    b_o     = b_i >> RADIX_BITS;
  end

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequencing controller for the multi-cycle MUL unit (low XLEN bits of the product).
// Optional build macro: MUL_EARLY_OUT_EN -- finish as soon as the remaining
// multiplier is zero (data-dependent latency). Undefined: fixed N+1 cycles.
module mul_seq_ctrl #(
  parameter int XLEN       = mul_seq_ctrl_pkg::XLEN,
  parameter int RADIX_BITS = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  input  logic [XLEN-1:0]                       op_a,
  input  logic [XLEN-1:0]                       op_b,
  input  logic                                  kill,
  output logic                                  mul_busy,
  output logic                                  done,
  output logic [XLEN-1:0]                       result,
  output logic [$clog2(XLEN/RADIX_BITS+1)-1:0]  iter_cnt
);

  import mul_seq_ctrl_pkg::*;

  localparam int N     = XLEN / RADIX_BITS;
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] N_CNT   = CNT_W'(N);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  mul_state_t        state_q, state_d;
  logic [XLEN-1:0]   a_q, a_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [XLEN-1:0]   step_acc_s, step_a_s, step_b_s;

  mul_radix_step #(
    .XLEN       (XLEN),
    .RADIX_BITS (RADIX_BITS)
  ) u_step (
    .acc_i (acc_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .acc_o (step_acc_s),
    .a_o   (step_a_s),
    .b_o   (step_b_s)
  );

  // State and datapath registers; reset clears everything regardless of state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
    end
  end

  // Next-state, datapath update and the combinational stall request.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    mul_busy = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && !kill) begin
          // Stall in the accept cycle itself so EX does not advance.
          mul_busy = 1'b1;
          a_d      = op_a;
          b_d      = op_b;
          acc_d    = '0;
`ifdef MUL_EARLY_OUT_EN
          if (op_b == '0) begin
            state_d  = DONE;
            result_d = '0;
            cnt_d    = '0;
          end else begin
            state_d  = RUN;
            cnt_d    = N_CNT;
          end
`else
          state_d  = RUN;
          cnt_d    = N_CNT;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        mul_busy = 1'b1;
        if (kill) begin
          // Flushed instruction: abandon quietly, result keeps its old value.
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc_s;
          a_d   = step_a_s;
          b_d   = step_b_s;
          cnt_d = cnt_q - ONE_CNT;
`ifdef MUL_EARLY_OUT_EN
          if ((cnt_q == ONE_CNT) || (step_b_s == '0)) begin
`else
          if (cnt_q == ONE_CNT) begin
`endif
            state_d  = DONE;
            result_d = step_acc_s;
            cnt_d    = '0;
          end else begin
            state_d = RUN;
          end
        end
      end
      DONE: begin
        // Instruction completes on this edge; kill and req_valid are ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign iter_cnt = cnt_q;

endmodule
